// File: rtl/polar_encoder_pkg.sv
// Shared definitions for the polar encoder.
// Holds the FSM state type, the code-size constants, and small helper
// functions: legal-N check, log2 of a legal N, and a binomial coefficient
// used by the reliability ranking.
package polar_encoder_pkg;

    localparam int NMAX     = 512;
    localparam int LOGN_MAX = 9;

    localparam logic [9:0] N_128 = 10'd128;
    localparam logic [9:0] N_256 = 10'd256;
    localparam logic [9:0] N_512 = 10'd512;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ENCODE = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    function automatic logic legal_n(input logic [9:0] n);
        return (n == N_128) || (n == N_256) || (n == N_512);
    endfunction

    // Only meaningful for a legal N.
    function automatic logic [3:0] log2_n(input logic [9:0] n);
        if (n[9]) begin
            return 4'd9;
        end else if (n[8]) begin
            return 4'd8;
        end
        return 4'd7;
    endfunction

    // C(n, k) for n, k <= 9, built by stepping Pascal's triangle n times.
    function automatic logic [8:0] binom(input logic [3:0] n, input logic [3:0] k);
        logic [8:0] row [16];
        for (int j = 0; j < 16; j++) begin
            row[4'(j)] = '0;
        end
        row[0] = 9'd1;
        for (int r = 1; r <= LOGN_MAX; r++) begin
            if (4'(r) <= n) begin
                for (int j = LOGN_MAX; j >= 1; j--) begin
                    row[4'(j)] = row[4'(j)] + row[4'(j - 1)];
                end
            end
        end
        return row[k];
    endfunction

endpackage

// File: rtl/polar_encoder_reliability_lut.sv
// reliability_LUT: reliability rank of a synthetic channel for N = 128/256/512.
// Ports:
//   N_channel         in  2  N[9:8]: 00 -> 128, 01 -> 256, 10 -> 512
//   channel_index     in  9  channel number, < N
//   reliability_index out 9  rank 0 (least reliable) .. N-1 (most reliable)
// Channels are ranked by Hamming weight of their index, ties broken by
// index value. rank = (#indices of lower weight) + (#indices of equal weight
// and smaller value); the latter is the combinatorial number system sum
// C(p_1,1) + C(p_2,2) + ... over the set-bit positions p_1 < p_2 < ...
module reliability_LUT
    import polar_encoder_pkg::*;
(
    input  logic [1:0] N_channel,
    input  logic [8:0] channel_index,
    output logic [8:0] reliability_index
);

    logic [3:0] n_log;
    logic [3:0] ones;
    logic [9:0] rank;

    always_comb begin
        case (N_channel)
            2'b00:   n_log = 4'd7;
            2'b01:   n_log = 4'd8;
            default: n_log = 4'd9;
        endcase
    end

    always_comb begin
        rank = '0;
        ones = '0;
        for (int p = 0; p < LOGN_MAX; p++) begin
            if ((4'(p) < n_log) && channel_index[4'(p)]) begin
                ones = ones + 4'd1;
                rank = rank + {1'b0, binom(4'(p), ones)};
            end
        end
        for (int w = 0; w < LOGN_MAX; w++) begin
            if (4'(w) < ones) begin
                rank = rank + {1'b0, binom(n_log, 4'(w))};
            end
        end
    end

    assign reliability_index = rank[8:0];

endmodule

// File: rtl/polar_encoder.sv
// polar_encoder: serial polar encoder, x = u * F^(kron n), natural order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, N, K           start pulse; N in {128,256,512}, K info bits
//   in_valid/in_bit/in_ready     info-bit stream in
//   out_valid/out_bit/out_ready  codeword stream out, out_last on x[N-1]
//   busy                  frame in progress
//   dbg_state_o           current FSM state (state_e encoding)
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; the producer holds its data stable while valid & ~ready, and
// ready never depends combinationally on valid.
module polar_encoder
    import polar_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] N,
    input  logic [7:0] K,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    input  logic       out_ready,
    output logic       busy,
    output logic       out_last,
    output logic [1:0] dbg_state_o
);

    state_e          state_q, state_d;
    logic [9:0]      n_q, n_d;
    logic [7:0]      k_q, k_d;
    logic [8:0]      ch_idx_q, ch_idx_d;
    logic [3:0]      s_q, s_d;
    logic [8:0]      out_idx_q, out_idx_d;
    logic [NMAX-1:0] u_q, u_d;

    logic [8:0] rindex;
    logic [9:0] frozen_limit;
    logic [3:0] log_n;
    logic       frozen, start_ok, ch_last, ch_adv, last_stage, out_hs, out_end;

    reliability_LUT u_lut (
        .N_channel         (n_q[9:8]),
        .channel_index     (ch_idx_q),
        .reliability_index (rindex)
    );

    // Same rule the decoder uses: the N-K least reliable channels are frozen.
    assign frozen_limit = n_q - {2'b00, k_q};
    assign frozen       = ({1'b0, rindex} < frozen_limit);
    assign start_ok     = start & legal_n(N);
    assign ch_last      = ({1'b0, ch_idx_q} == (n_q - 10'd1));
    // In LOAD a frozen channel always advances; an info channel needs in_valid.
    assign ch_adv       = (state_q == ST_LOAD) & (frozen | in_valid);
    assign log_n        = log2_n(n_q);
    assign last_stage   = (s_q == (log_n - 4'd1));
    assign out_hs       = out_valid & out_ready;
    assign out_end      = out_hs & out_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok)            state_d = ST_LOAD;
            ST_LOAD:   if (ch_adv && ch_last)   state_d = ST_ENCODE;
            ST_ENCODE: if (last_stage)          state_d = ST_OUTPUT;
            ST_OUTPUT: if (out_end)             state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Outputs, all decoded from registered state
    always_comb begin
        in_ready    = (state_q == ST_LOAD) & ~frozen;
        out_valid   = (state_q == ST_OUTPUT);
        out_bit     = out_valid & u_q[out_idx_q];
        out_last    = out_valid & ({1'b0, out_idx_q} == (n_q - 10'd1));
        busy        = (state_q != ST_IDLE);
        dbg_state_o = state_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= '0;
            k_q       <= '0;
            ch_idx_q  <= '0;
            s_q       <= '0;
            out_idx_q <= '0;
            u_q       <= '0;
        end else begin
            n_q       <= n_d;
            k_q       <= k_d;
            ch_idx_q  <= ch_idx_d;
            s_q       <= s_d;
            out_idx_q <= out_idx_d;
            u_q       <= u_d;
        end
    end

    // Datapath next-state
    always_comb begin
        n_d       = n_q;
        k_d       = k_q;
        ch_idx_d  = ch_idx_q;
        s_d       = s_q;
        out_idx_d = out_idx_q;
        u_d       = u_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    n_d      = N;
                    k_d      = K;
                    ch_idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (ch_adv) begin
                    u_d[ch_idx_q] = frozen ? 1'b0 : in_bit;
                    ch_idx_d      = ch_idx_q + 9'd1;
                    if (ch_last) begin
                        s_d = '0;
                    end
                end
            end
            ST_ENCODE: begin
                // One butterfly stage per cycle. Stages below log2(N) never
                // pair an index < N with one >= N, so stale upper bits from a
                // larger previous frame cannot reach the output.
                for (int st = 0; st < LOGN_MAX; st++) begin
                    if (s_q == 4'(st)) begin
                        for (int i = 0; i < NMAX; i++) begin
                            if (((i >> st) & 1) == 0) begin
                                u_d[9'(i)] = u_q[9'(i)] ^ u_q[9'(i + (1 << st))];
                            end
                        end
                    end
                end
                s_d = s_q + 4'd1;
                if (last_stage) begin
                    out_idx_d = '0;
                end
            end
            ST_OUTPUT: begin
                if (out_end) begin
                    out_idx_d = '0;
                end else if (out_hs) begin
                    out_idx_d = out_idx_q + 9'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_polar_encoder.sv
module tb_polar_encoder;
    import polar_encoder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] N;
    logic [7:0] K;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_ready;
    logic       busy;
    logic       out_last;
    logic [1:0] dbg_state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int FRAME_BUDGET = 6000;

    polar_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .N           (N),
        .K           (K),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .out_ready   (out_ready),
        .busy        (busy),
        .out_last    (out_last),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector record ----------------
    // bits_mode: 0 = all ones, 1 = only first bit one, 2 = random
    typedef struct {
        int           n;
        int           k;
        int           bits_mode;
        bit           rand_hs;
        bit           poke_start;
        bit           use_model;
        logic [511:0] exp_x;
        int           exp_hs;
        int           exp_enc;
    } vec_t;

    vec_t vecs [8];

    // ---------------- checkers ----------------
    task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int popc(input int v);
        int c = 0;
        for (int b = 0; b < 10; b++) c += (v >> b) & 1;
        return c;
    endfunction

    // Brute-force rank: weight first, then index.
    function automatic int rel_rank(input int n, input int c);
        int r  = 0;
        int wc = popc(c);
        for (int j = 0; j < n; j++) begin
            if ((popc(j) < wc) || ((popc(j) == wc) && (j < c))) r++;
        end
        return r;
    endfunction

    // x[j] = XOR of u[i] over all i whose bits are a superset of j's bits.
    function automatic logic [511:0] encode_model(input logic [511:0] u, input int n);
        logic [511:0] x = '0;
        for (int j = 0; j < n; j++) begin
            logic b = 1'b0;
            for (int i = 0; i < n; i++) begin
                if ((j & ~i) == 0) b ^= u[9'(i)];
            end
            x[9'(j)] = b;
        end
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int n, input int k);
        N     = 10'(n);
        K     = 8'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit           info_q[$];
        int           exp_ch[$];
        int           got_ch[$];
        logic [511:0] u_model, exp_x, got_x;
        int           ch, ptr, hs, enc, oi, cyc, stab_err, last_err, hs_err, last_rec, map_err;
        bit           stalled, prev_bit, prev_last, iv, ordy;

        for (int i = 0; i < v.k; i++) begin
            case (v.bits_mode)
                0:       info_q.push_back(1'b1);
                1:       info_q.push_back(i == 0);
                default: info_q.push_back(1'($urandom_range(0, 1)));
            endcase
        end
        u_model = '0;
        ptr     = 0;
        for (int c = 0; c < v.n; c++) begin
            if (rel_rank(v.n, c) >= v.n - v.k) begin
                exp_ch.push_back(c);
                u_model[9'(c)] = info_q[ptr];
                ptr++;
            end
        end
        exp_x = v.use_model ? encode_model(u_model, v.n) : v.exp_x;

        ch = 0; ptr = 0; hs = 0; enc = 0; oi = 0; cyc = 0;
        stab_err = 0; last_err = 0; hs_err = 0; last_rec = -1;
        stalled = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
        got_x = '0;

        start_frame(v.n, v.k);
        while (oi < v.n && cyc < FRAME_BUDGET) begin
            if (in_ready && dbg_state_o != ST_LOAD) hs_err++;
            if (out_valid !== (dbg_state_o == ST_OUTPUT)) hs_err++;
            if (dbg_state_o == ST_LOAD) begin
                if (in_ready && ch != last_rec) begin
                    got_ch.push_back(ch);
                    last_rec = ch;
                end
                iv = (ptr < info_q.size()) && (!v.rand_hs || $urandom_range(0, 3) != 0);
                in_valid = iv;
                in_bit   = iv ? info_q[ptr] : 1'b0;
                if (!in_ready) begin
                    ch++;
                end else if (iv) begin
                    ptr++;
                    hs++;
                    ch++;
                end
            end else begin
                in_valid = 1'b0;
                in_bit   = 1'b0;
            end
            if (dbg_state_o == ST_ENCODE) enc++;
            if (out_valid) begin
                if (stalled && (out_bit !== prev_bit || out_last !== prev_last)) stab_err++;
                ordy      = !v.rand_hs || ($urandom_range(0, 1) == 1);
                out_ready = ordy;
                if (ordy) begin
                    got_x[9'(oi)] = out_bit;
                    if (out_last !== (oi == v.n - 1)) last_err++;
                    oi++;
                end
                stalled   = !ordy;
                prev_bit  = out_bit;
                prev_last = out_last;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                stalled   = 1'b0;
            end
            // Start pulses while OUTPUT, including the final handshake cycle.
            start = v.poke_start && (dbg_state_o == ST_OUTPUT);
            if (start) begin
                N = 10'd128;
                K = 8'd5;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        if (cyc >= FRAME_BUDGET) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got %0d of %0d output bits, required all", tag, oi, v.n);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end

        check_int({tag, " busy_after_last"}, int'(busy), 0);
        check_int({tag, " state_after_last"}, int'(dbg_state_o), int'(ST_IDLE));
        @(negedge clk);
        check_int({tag, " idle_hold"}, int'({busy, dbg_state_o}), 0);

        map_err = (got_ch.size() != exp_ch.size()) ? 1 : 0;
        for (int i = 0; i < got_ch.size() && i < exp_ch.size(); i++) begin
            if (got_ch[i] != exp_ch[i]) map_err++;
        end
        check_int({tag, " handshakes"}, hs, v.exp_hs);
        check_int({tag, " info_channel_map_errors"}, map_err, 0);
        check_int({tag, " encode_cycles"}, enc, v.exp_enc);
        check_vec({tag, " codeword"}, got_x, exp_x);
        check_int({tag, " stall_stability_errors"}, stab_err, 0);
        check_int({tag, " out_last_errors"}, last_err, 0);
        check_int({tag, " ready_valid_state_errors"}, hs_err, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{n: 128, k: 128, bits_mode: 0, rand_hs: 1'b0, poke_start: 1'b0, use_model: 1'b0,
                    exp_x: (512'd1 << 127), exp_hs: 128, exp_enc: 7};
        vecs[1] = '{n: 128, k: 128, bits_mode: 1, rand_hs: 1'b0, poke_start: 1'b0, use_model: 1'b0,
                    exp_x: 512'd1, exp_hs: 128, exp_enc: 7};
        vecs[2] = '{n: 128, k: 1, bits_mode: 0, rand_hs: 1'b0, poke_start: 1'b0, use_model: 1'b0,
                    exp_x: {384'd0, {128{1'b1}}}, exp_hs: 1, exp_enc: 7};
        vecs[3] = '{n: 512, k: 200, bits_mode: 2, rand_hs: 1'b1, poke_start: 1'b1, use_model: 1'b1,
                    exp_x: '0, exp_hs: 200, exp_enc: 9};
        vecs[4] = '{n: 256, k: 100, bits_mode: 2, rand_hs: 1'b1, poke_start: 1'b0, use_model: 1'b1,
                    exp_x: '0, exp_hs: 100, exp_enc: 8};
        vecs[5] = '{n: 128, k: 60, bits_mode: 2, rand_hs: 1'b1, poke_start: 1'b0, use_model: 1'b1,
                    exp_x: '0, exp_hs: 60, exp_enc: 7};
        vecs[6] = '{n: 256, k: 0, bits_mode: 2, rand_hs: 1'b0, poke_start: 1'b1, use_model: 1'b0,
                    exp_x: '0, exp_hs: 0, exp_enc: 8};
        vecs[7] = '{n: 512, k: 255, bits_mode: 2, rand_hs: 1'b1, poke_start: 1'b0, use_model: 1'b1,
                    exp_x: '0, exp_hs: 255, exp_enc: 9};

        rst_n     = 1'b0;
        start     = 1'b0;
        N         = '0;
        K         = '0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("reset_outputs", 512'({in_ready, out_valid, out_bit, out_last, busy, dbg_state_o}), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Illegal N is ignored.
        start_frame(300, 10);
        check_int("illegal_n_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check_int("illegal_n_idle", int'({busy, dbg_state_o}), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of LOAD, then a fresh frame.
        start_frame(256, 100);
        repeat (60) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_int("mid_load_state", int'(dbg_state_o), int'(ST_LOAD));
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_vec("async_reset_outputs",
                  512'({in_ready, out_valid, out_bit, out_last, busy, dbg_state_o}), '0);
        @(negedge clk);
        @(negedge clk);
        check_vec("held_reset_outputs",
                  512'({in_ready, out_valid, out_bit, out_last, busy, dbg_state_o}), '0);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[4], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/polar_encoder.md
POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: start  input  1  one-cycle pulse, latches N and K, begins a frame.
REQ-004 SHALL have: N  input  10  code length; only 128, 256 or 512 are legal.
REQ-005 SHALL have: K  input  8  number of info bits, 0..min(N,255).
REQ-006 SHALL have: in_valid  input  1  and in_bit  input  1  serial info-bit stream.
REQ-007 SHALL have: in_ready  output  1  info bit accepted when in_valid & in_ready.
REQ-008 SHALL have: out_valid  output  1  and out_bit  output  1  serial codeword bit x[i].
REQ-009 SHALL have: out_ready  input  1  codeword bit consumed when out_valid & out_ready.
REQ-010 SHALL have: busy  output  1  high from the accepted start until the last codeword bit is consumed.
REQ-011 SHALL have: out_last  output  1  high with out_valid on bit index N-1.

Function
REQ-012 SHALL run the FSM IDLE -> LOAD -> ENCODE -> OUTPUT -> IDLE.
REQ-013 IDLE: start with a legal N latches N, K, sets ch_idx=0 and enters LOAD; start with an illegal N is ignored.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 LOAD SHALL step ch_idx 0..N-1 and classify each channel: frozen iff reliability_index(ch_idx) < N-K.
REQ-016 Frozen channel: u[ch_idx]=0 and ch_idx advances in one cycle with in_ready low.
REQ-017 Non-frozen channel: in_ready is high; ch_idx advances only on an in_valid handshake, storing u[ch_idx]=in_bit.
REQ-018 Info bits SHALL map to non-frozen channels in ascending channel index.
REQ-019 Exactly K handshakes SHALL occur per frame; in_ready is never high outside LOAD.
REQ-020 Leaving LOAD after ch_idx=N-1 SHALL clear stage counter s=0.
REQ-021 ENCODE SHALL perform one butterfly stage per cycle, s = 0..log2(N)-1 (7, 8 or 9 cycles).
REQ-022 Each stage: for every i<N with bit s of i clear, u[i] <= u[i] ^ u[i + 2^s]; the result is x = u·F^(⊗n) in natural order, with no bit reversal.
REQ-023 OUTPUT SHALL present x[0]..x[N-1] in order; out_valid is high for the whole state.
REQ-024 out_bit and out_last SHALL hold stable while out_valid & ~out_ready.
REQ-025 The handshake on index N-1 SHALL return the FSM to IDLE in the next cycle, with busy low.
REQ-026 A start arriving in the same cycle as the final output handshake SHALL be ignored; it is accepted only in IDLE.
REQ-027 Register-bank bits at index >= N SHALL be unused and SHALL NOT affect the output.

Reset
REQ-028 rst_n low at any time SHALL asynchronously force IDLE and clear ch_idx, s, the out index, in_ready, out_valid, out_bit, out_last and busy; a frame in flight is discarded.
REQ-029 The 512-bit u register bank SHALL also clear to 0 on reset.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef, NMAX=512, LOGN_MAX=9 and the legal-N constants 128/256/512.
REQ-031 The existing reliability_LUT SHALL be instantiated once as the sole sub-module.
REQ-032 Its ports SHALL be N_channel=N[9:8], channel_index=ch_idx, reliability_index=9-bit rindex.
REQ-033 The frozen decision SHALL match the decoder rule exactly: rindex < N-K.

Verification
REQ-034 N=128, K=128, all in_bit=1 -> 128 handshakes; output has x[127]=1 and every other bit 0.
REQ-035 N=128, K=128, in_bit=1 only for the first bit -> x[0]=1, all others 0, out_last on index 127.
REQ-036 N=128, K=1, in_bit=1 -> the single in_ready occurs at the channel with rindex=127; output is all 128 bits = 1 when that channel is 127.
REQ-037 N=512, K=200, random bits, out_ready toggled randomly -> stream matches a golden u·F^(⊗9) model; out_bit is stable during stalls; ENCODE lasts 9 cycles.
REQ-038 N=256, K=100, rst_n pulsed low mid-LOAD, then a new start -> all outputs are 0 during reset and the second frame is correct.
REQ-039 start with N=300 -> ignored, busy stays low; start pulsed during OUTPUT -> ignored.
